// File: rtl/fec_encoder.sv
// fec_encoder: rate-1/2 tail-biting convolutional encoder (K=7), G1/G2 generators.
// Captures serial uncoded bits into a two-bank ping-pong buffer, BLOCK_BITS per
// block, and emits 2*BLOCK_BITS coded bits per block, X/Y interleaved.
// Ports:
//   clock_100  - single clock, rising edge
//   reset      - synchronous, active-high
//   in_valid   - upstream bit valid
//   in_data    - uncoded bit
//   in_ready   - a bit is accepted when in_valid && in_ready
//   out_valid  - coded bit valid
//   out_data   - coded bit (X0,Y0,X1,Y1,...)
//   out_ready  - downstream accepts when out_valid && out_ready
//   out_first  - marks X0 of each block
module fec_encoder #(
  parameter int         BLOCK_BITS = 96,
  parameter logic [6:0] G1         = 7'o171,
  parameter logic [6:0] G2         = 7'o133
) (
  input  logic clock_100,
  input  logic reset,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
  input  logic out_ready,
  output logic out_first
);

  localparam int              IW   = $clog2(BLOCK_BITS);
  localparam logic [IW-1:0]   LAST = IW'(BLOCK_BITS - 1);

  typedef enum logic [1:0] {IDLE, PRELOAD, ENCODE} state_t;

  state_t                 state, state_next;
  logic [BLOCK_BITS-1:0]  bank [2];
  logic [1:0]             full;
  logic                   wr_bank, rd_bank;
  logic [IW-1:0]          wr_cnt, rd_idx;
  logic                   phase;
  logic [5:0]             sr;

  logic       wr_fire, wr_done, rd_fire, rd_done;
  logic       u, x, y;
  logic [6:0] taps;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_cnt == LAST);
  assign rd_fire  = (state == ENCODE) && out_ready;
  assign rd_done  = rd_fire && phase && (rd_idx == LAST);

  // Generator MSB is the current input; lower taps walk back through history.
  assign u    = bank[rd_bank][rd_idx];
  assign taps = {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
  assign x    = ^(taps & G1);
  assign y    = ^(taps & G2);

  assign out_valid = (state == ENCODE);
  assign out_first = out_valid && (rd_idx == '0) && !phase;
  // Gated so the output reads 0 outside ENCODE regardless of buffer contents.
  assign out_data  = out_valid && (phase ? y : x);

  // Block storage needs no reset: partial blocks are discarded via wr_cnt.
  always_ff @(posedge clock_100) begin
    if (wr_fire) bank[wr_bank][wr_cnt] <= in_data;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (full[rd_bank]) state_next = PRELOAD;
      PRELOAD: state_next = ENCODE;
      ENCODE:  if (rd_done) state_next = full[!rd_bank] ? PRELOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_100) begin
    if (reset) begin
      state   <= IDLE;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_idx  <= '0;
      phase   <= 1'b0;
      sr      <= '0;
    end else begin
      state <= state_next;
      // Write completion and read release always hit different banks.
      full  <= (full | (2'(wr_done) << wr_bank)) & ~(2'(rd_done) << rd_bank);

      if (wr_fire) begin
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (state == PRELOAD) begin
        // Tail-biting: start from the last six bits of the block.
        for (int unsigned k = 0; k < 6; k++)
          sr[k] <= bank[rd_bank][BLOCK_BITS-1-k];
        rd_idx <= '0;
        phase  <= 1'b0;
      end else if (rd_fire) begin
        if (!phase) begin
          phase <= 1'b1;
        end else begin
          phase  <= 1'b0;
          sr     <= {sr[4:0], u};
          rd_idx <= rd_done ? '0 : rd_idx + 1'b1;
        end
        if (rd_done) rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fec_encoder.sv
// Scoreboard bench for fec_encoder: stimulus pushes expected coded bits
// ({last, first, data}) into a queue, a negedge monitor pops and compares.
module tb_fec_encoder;

  logic clock_100 = 1'b0;
  logic reset, in_valid, in_data, in_ready, out_valid, out_data, out_ready, out_first;

  fec_encoder #(.BLOCK_BITS(96), .G1(7'o171), .G2(7'o133)) dut (
    .clock_100 (clock_100),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_first (out_first)
  );

  always #5 clock_100 = ~clock_100;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nout  = 0;

  logic [2:0] exp_q [$];

  // Monitor-side arming flags set by the stimulus.
  bit lat_arm   = 0;
  int t95       = 0;
  bit rdy_arm   = 0;
  bit rdy_next  = 0;
  int bub_arm   = 0;
  int last_cyc  = 0;

  bit   stall_prev = 0;
  logic held_d, held_f;
  logic [2:0] e;

  always @(posedge clock_100) cyc++;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock_100) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (rdy_next) begin
        check("in_ready_after_y95", in_ready, 1'b1);
        rdy_next = 0;
      end
      if (stall_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_d);
        check("hold_first", out_first, held_f);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got data=%b first=%b want nothing", out_data, out_first);
        end else begin
          e = exp_q.pop_front();
          total++;
          if ({out_first, out_data} !== e[1:0]) begin
            bad++;
            $display("FAIL out_bit%0d: got first=%b data=%b want first=%b data=%b",
                     nout, out_first, out_data, e[1], e[0]);
          end
          if (e[1] && lat_arm) begin
            // t95 is taken just after the accepting edge; X0 shows after two more edges.
            check_int("first_latency", cyc - t95, 2);
            lat_arm = 0;
          end
          if (e[1] && bub_arm > 0) begin
            check_int("block_bubble", cyc - last_cyc, 2);
            bub_arm--;
          end
          if (e[2]) begin
            last_cyc = cyc;
            if (rdy_arm) begin
              check("in_ready_low_both_full", in_ready, 1'b0);
              rdy_arm  = 0;
              rdy_next = 1;
              bub_arm  = 2;
            end
          end
        end
        nout++;
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_f = out_first;
    end
  end

  task automatic push_exp(input logic [191:0] bits);
    for (int j = 0; j < 192; j++)
      exp_q.push_back({(j == 191), (j == 0), bits[j]});
  endtask

  // Circular reference encoder: history is read straight out of the block.
  function automatic logic [191:0] model_enc(input logic [95:0] blk);
    logic [191:0] r;
    logic p1, p2, p3, p4, p5, p6;
    for (int i = 0; i < 96; i++) begin
      p1 = blk[(i + 95) % 96];
      p2 = blk[(i + 94) % 96];
      p3 = blk[(i + 93) % 96];
      p4 = blk[(i + 92) % 96];
      p5 = blk[(i + 91) % 96];
      p6 = blk[(i + 90) % 96];
      r[2*i]   = blk[i] ^ p1 ^ p2 ^ p3 ^ p6;
      r[2*i+1] = blk[i] ^ p2 ^ p3 ^ p5 ^ p6 ^ (p4 & 1'b0);
    end
    return r;
  endfunction

  // Sends bits 0..n-1; expected stream is pushed once a full block is in.
  task automatic send_bits(input logic [95:0] blk, input int n, input logic [191:0] expv,
                           input bit arm_lat);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      guard    = 0;
      do begin
        @(negedge clock_100);
        acc = in_ready;
        @(posedge clock_100);
        #1;
        guard++;
      end while (!acc && guard < 2000);
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL in_handshake_timeout: got in_ready=0 want 1 bit %0d", i);
        in_valid = 1'b0;
        return;
      end
    end
    if (n == 96) begin
      if (arm_lat) begin
        t95     = cyc;
        lat_arm = 1;
      end
      push_exp(expv);
    end
  endtask

  task automatic stop_input();
    in_valid = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
      @(posedge clock_100);
      #1;
      guard++;
    end
    check_int("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_nout(input int target);
    int guard = 0;
    while (nout < target && guard < 3000) begin
      @(posedge clock_100);
      #1;
      guard++;
    end
    check_int("wait_output_count", (nout >= target) ? 1 : 0, 1);
  endtask

  logic [95:0]  blk, blk1, blk2;
  logic [191:0] ex;
  logic [13:0]  pat14;
  logic [11:0]  pat12;
  int           base;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock_100);
    #1 reset = 1'b0;
    @(negedge clock_100);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 1'b0);
    check("reset_out_first", out_first, 1'b0);
    @(posedge clock_100);
    #1;

    // All-zero block with latency check.
    blk = '0;
    send_bits(blk, 96, 192'd0, 1);
    stop_input();
    wait_drain();

    // Impulse at bit 0.
    blk   = 96'd1;
    pat14 = 14'b11101111000111;
    ex    = '0;
    for (int j = 0; j < 14; j++) ex[j] = pat14[13-j];
    send_bits(blk, 96, ex, 0);
    stop_input();
    wait_drain();

    // Impulse at bit 95 exercises tail-biting preload.
    blk   = 96'd1 << 95;
    pat12 = 12'b101111000111;
    ex    = '0;
    for (int j = 0; j < 12; j++) ex[j] = pat12[11-j];
    ex[190] = 1'b1;
    ex[191] = 1'b1;
    send_bits(blk, 96, ex, 0);
    stop_input();
    wait_drain();

    // All ones.
    blk = '1;
    send_bits(blk, 96, '1, 0);
    stop_input();
    wait_drain();

    // Backpressure for 10 cycles at bit 50.
    blk  = {$urandom, $urandom, $urandom};
    base = nout;
    send_bits(blk, 96, model_enc(blk), 0);
    stop_input();
    wait_nout(base + 100);
    out_ready = 1'b0;
    repeat (10) @(posedge clock_100);
    #1 out_ready = 1'b1;
    wait_drain();

    // Three back-to-back blocks with continuous in_valid.
    blk  = {$urandom, $urandom, $urandom};
    blk1 = {$urandom, $urandom, $urandom};
    blk2 = {$urandom, $urandom, $urandom};
    rdy_arm = 1;
    send_bits(blk, 96, model_enc(blk), 0);
    send_bits(blk1, 96, model_enc(blk1), 0);
    send_bits(blk2, 96, model_enc(blk2), 0);
    stop_input();
    wait_drain();
    check_int("bubble_checks_done", bub_arm, 0);

    // Reset mid-encode (rd_idx=40) and mid-capture (wr_cnt=30).
    blk  = {$urandom, $urandom, $urandom};
    blk1 = {$urandom, $urandom, $urandom};
    base = nout;
    send_bits(blk, 96, model_enc(blk), 0);
    send_bits(blk1, 30, '0, 0);
    stop_input();
    wait_nout(base + 80);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock_100);
    #1 reset = 1'b0;
    @(negedge clock_100);
    check("post_reset_out_valid", out_valid, 1'b0);
    check("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clock_100);
    #1;

    // Clean block after reset.
    blk = {$urandom, $urandom, $urandom};
    send_bits(blk, 96, model_enc(blk), 1);
    stop_input();
    wait_drain();

    repeat (5) @(posedge clock_100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fec_encoder.md
# fec_encoder

Rate-1/2 tail-biting convolutional encoder (K=7, generators 171/133 octal) for the WiMAX PHY transmit chain. It sits directly upstream of the interleaver. It consumes the randomizer's serial bit stream in 96-bit blocks and emits 192 coded bits per block, serially, to the interleaver. A two-bank ping-pong buffer lets one block be captured while the previous block is encoded.

## Interface
- BLOCK_BITS, 96, uncoded bits per FEC block (output block = 2*BLOCK_BITS).
- G1, 7'o171, generator for X output (MSB = current input tap).
- G2, 7'o133, generator for Y output (MSB = current input tap).
- clock_100  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- in_valid  in  1  upstream bit valid.
- in_data  in  1  uncoded bit.
- in_ready  out  1  encoder can accept a bit; transfer when in_valid && in_ready.
- out_valid  out  1  coded bit valid.
- out_data  out  1  coded bit (X/Y interleaved).
- out_ready  in  1  interleaver accepts; transfer when out_valid && out_ready.
- out_first  out  1  high with out_valid on the first coded bit (X0) of each block.

## Operation
- Storage: two banks of BLOCK_BITS flops, flags full[1:0], wr_bank, wr_cnt (0..95), rd_bank, rd_idx (0..95), phase (0=X, 1=Y), shift register sr[5:0] (sr[0] = most recent previous input).
- Write side: in_ready = !full[wr_bank]. On transfer, bank[wr_bank][wr_cnt] <= in_data. If wr_cnt==95: full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0; else wr_cnt++.
- Read FSM states:
  - IDLE: if full[rd_bank], go to PRELOAD.
  - PRELOAD (1 cycle): tail-biting init, sr[k] <= bank[rd_bank][95-k] for k=0..5; rd_idx <= 0, phase <= 0; go to ENCODE.
  - ENCODE: u = bank[rd_bank][rd_idx].
- Encoder equations:
  - X = u^sr[0]^sr[1]^sr[2]^sr[5].
  - Y = u^sr[1]^sr[2]^sr[4]^sr[5].
  - out_data = phase ? Y : X.
- Output order per block: X0,Y0,X1,Y1,...,X95,Y95.
- ENCODE on output transfer:
  - phase 0: phase <= 1.
  - phase 1: phase <= 0, sr <= {sr[4:0],u}, rd_idx++.
  - Transfer of Y95: full[rd_bank] <= 0, rd_bank toggles. Next state is PRELOAD if the other bank is full, else IDLE.
- out_valid = (state==ENCODE). out_first = ENCODE && rd_idx==0 && phase==0.
- Outputs derive only from registered state. No combinational path from out_ready or in_valid to any output.
- Simultaneous events: write-completion on one bank and read-release on the other in the same cycle both take effect. The write side never targets a full bank; the read side never targets a non-full bank.
- Reset, including mid-block: state=IDLE, full=0, wr_bank=rd_bank=0, wr_cnt=rd_idx=0, phase=0, sr=0. Partial blocks are discarded.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_first=0.

## Timing
- Input accepts 1 bit/cycle until both banks are full.
- If bit 95 is accepted in cycle t:
  - t+1: IDLE sees full.
  - t+2: PRELOAD.
  - t+3: out_valid=1 with X0 (3-cycle latency).
- Output: 1 bit/cycle under continuous out_ready; 193 cycles per block back-to-back (192 data + 1 PRELOAD bubble).
- Sustained input rate is therefore capped at 96 bits per 193 cycles. in_ready drops when both banks are full and rises the cycle after Y95 transfers.
- Backpressure: while out_valid && !out_ready, out_data, out_first, phase, rd_idx and sr hold.

## Test plan
- All-zero block, out_ready=1 -> 192 zeros; out_first pulses once on X0; first out_valid 3 cycles after the cycle bit 95 is accepted.
- Block with bit0=1, rest 0 -> pairs (X,Y): 11,10,11,11,00,01,11, then 178 zeros.
- Tail-biting: bit95=1, rest 0 -> pairs 10,11,11,00,01,11, then zeros, with the final pair (X95,Y95)=11. All-ones block -> 192 ones.
- Backpressure: random block, out_ready low 10 cycles at bit 50 -> data held stable; stream equals golden model bit-exact, no loss or duplication.
- Continuous in_valid for 3 blocks -> in_ready low once both banks are full, high the cycle after Y95 of block 0. All 3 blocks are output in order with a 1-cycle bubble between blocks.
- Reset asserted mid-encode (rd_idx=40) and mid-capture (wr_cnt=30) -> out_valid=0 and in_ready=1 next cycle. Next full block is encoded correctly from a clean state.
